// File: rtl/regfile_wb_2r1w_pkg.sv
// regfile_wb_2r1w_pkg: shared widths, constants and write-back request type for regfile_wb_2r1w
package regfile_wb_2r1w_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS = 2 ** ADDR_W_DEF;
    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_2r1w_wb_pend_buf.sv
// wb_pend_buf: one-entry write-back capture register between the dest-select mux and the array
module wb_pend_buf
    import regfile_wb_2r1w_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] pend_data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= we;
            if (we) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_2r1w.sv
// regfile_wb_2r1w: 32-entry 2-read/1-write register file behind a one-entry write-back buffer.
// Define REGFILE_WB_FORWARD_EN to bypass pending data to the read ports instead of flagging a hazard.
module regfile_wb_2r1w
    import regfile_wb_2r1w_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_hazard1,
    output logic              rd_hazard2,
    output logic              pend_valid
);
    localparam int N = 2 ** ADDR_W;

    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] mem [N];
    logic              m1, m2;

    wb_pend_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_valid(pend_valid),
        .pend_addr (pend_addr),
        .pend_data (pend_data)
    );

    // commit drains the old buffer contents on the same edge the buffer refills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= RESET_VAL;
        end else if (pend_valid && pend_addr != '0) begin
            mem[pend_addr] <= pend_data;
        end
    end

    assign m1 = pend_valid && pend_addr == rd_addr1 && rd_addr1 != '0;
    assign m2 = pend_valid && pend_addr == rd_addr2 && rd_addr2 != '0;

`ifdef REGFILE_WB_FORWARD_EN
    assign rd_data1   = rd_addr1 == '0 ? '0 : m1 ? pend_data : mem[rd_addr1];
    assign rd_data2   = rd_addr2 == '0 ? '0 : m2 ? pend_data : mem[rd_addr2];
    assign rd_hazard1 = 1'b0;
    assign rd_hazard2 = 1'b0;
`else
    // stale array value is returned; the hazard tells upstream to stall one cycle
    assign rd_data1   = rd_addr1 == '0 ? '0 : mem[rd_addr1];
    assign rd_data2   = rd_addr2 == '0 ? '0 : mem[rd_addr2];
    assign rd_hazard1 = m1;
    assign rd_hazard2 = m2;
`endif
endmodule

// File: tb/tb_regfile_wb_2r1w.sv
// tb_regfile_wb_2r1w: directed self-checking bench for regfile_wb_2r1w (either REGFILE_WB_FORWARD_EN build)
module tb_regfile_wb_2r1w;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wr_addr, rd_addr1, rd_addr2;
    logic [31:0] wr_data, rd_data1, rd_data2;
    logic        rd_hazard1, rd_hazard2, pend_valid;
    int          checks = 0;
    int          errors = 0;
`ifdef REGFILE_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    regfile_wb_2r1w dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_hazard1(rd_hazard1),
        .rd_hazard2(rd_hazard2),
        .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = 5'd3; rd_addr2 = 5'd31;
        #1;
        chk("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
        chk("rst_rd1", rd_data1, 32'd0);
        chk("rst_rd2", rd_data2, 32'd0);
        chk("rst_haz", {30'd0, rd_hazard1, rd_hazard2}, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic write 12 <= AA
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_00AA; rd_addr1 = 5'd12; rd_addr2 = 5'd12;
        tick();
        we = 1'b0;
        #1;
        chk("pend_after_write", {31'd0, pend_valid}, 32'd1);
        chk("window_rd2", rd_data2, FWD ? 32'hAA : 32'h0);
        chk("window_haz2", {31'd0, rd_hazard2}, FWD ? 32'd0 : 32'd1);
        chk("window_rd1_eq_rd2", rd_data1, FWD ? 32'hAA : 32'h0);
        tick();
        chk("basic_rd1", rd_data1, 32'hAA);
        chk("basic_haz1", {31'd0, rd_hazard1}, 32'd0);
        chk("basic_pend_clear", {31'd0, pend_valid}, 32'd0);

        // back-to-back writes to 6
        rd_addr1 = 5'd6;
        we = 1'b1; wr_addr = 5'd6; wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        #1;
        chk("b2b_mid_rd", rd_data1, FWD ? 32'h11 : 32'h0);
        chk("b2b_mid_haz", {31'd0, rd_hazard1}, FWD ? 32'd0 : 32'd1);
        tick();
        we = 1'b0;
        #1;
        chk("b2b_second_rd", rd_data1, FWD ? 32'h22 : 32'h11);
        chk("b2b_pend_valid", {31'd0, pend_valid}, 32'd1);
        tick();
        chk("b2b_final", rd_data1, 32'h22);
        chk("b2b_final_haz", {31'd0, rd_hazard1}, 32'd0);

        // zero register
        rd_addr1 = 5'd0;
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        #1;
        chk("zero_pend_valid", {31'd0, pend_valid}, 32'd1);
        chk("zero_rd_pending", rd_data1, 32'h0);
        chk("zero_haz_pending", {31'd0, rd_hazard1}, 32'd0);
        tick();
        chk("zero_pend_clear", {31'd0, pend_valid}, 32'd0);
        chk("zero_rd_after", rd_data1, 32'h0);

        // dual-port same address
        rd_addr1 = 5'd31; rd_addr2 = 5'd31;
        we = 1'b1; wr_addr = 5'd31; wr_data = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;
        tick();
        chk("dual_rd1", rd_data1, 32'hDEAD_BEEF);
        chk("dual_rd2", rd_data2, 32'hDEAD_BEEF);
        rd_addr2 = 5'd12;
        #1;
        chk("dual_other_rd2", rd_data2, 32'hAA);

        // reset mid-operation discards the pending write
        rd_addr1 = 5'd5; rd_addr2 = 5'd31;
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
        tick();
        #2;
        rst_n = 1'b0; we = 1'b0;
        #1;
        chk("mid_rst_pend", {31'd0, pend_valid}, 32'd0);
        chk("mid_rst_rd1", rd_data1, 32'h0);
        chk("mid_rst_rd2", rd_data2, 32'h0);
        chk("mid_rst_haz", {30'd0, rd_hazard1, rd_hazard2}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rst_discard", rd_data1, 32'h0);
        rd_addr1 = 5'd12;
        #1;
        chk("mid_rst_rd12", rd_data1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_2r1w.md
Name: regfile_wb_2r1w

Overview:
- Register file that sits directly downstream of the 5-bit destination-register select mux.
- Consumes the selected 5-bit write address plus write-back data through a one-entry pending write-back buffer, then commits to a 32-entry array.
- Provides two combinational read ports to the decode stage.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, address width; the array holds 2**ADDR_W entries.
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write-back request valid this cycle.
- wr_addr  input  ADDR_W  destination register, driven by the upstream 5-bit select mux.
- wr_data  input  DATA_W  write-back data.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data (combinational).
- rd_data2  output  DATA_W  read port 2 data (combinational).
- rd_hazard1  output  1  read port 1 targets an uncommitted pending write.
- rd_hazard2  output  1  read port 2 targets an uncommitted pending write.
- pend_valid  output  1  pending write-back buffer occupied.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - All array entries go to RESET_VAL.
  - pend_valid=0, pend_addr=0, pend_data=0.
  - rd_hazard1/2=0.
  - rd_data1/2 reflect the reset array, i.e. 0 for all addresses when RESET_VAL=0.
- Reset deassertion: synchronous release; first capture happens on the first rising edge with rst_n high.
- Pending buffer, per rising edge:
  - pend_valid<=we.
  - If we: pend_addr<=wr_addr and pend_data<=wr_data.
  - If we=0: pend_addr and pend_data hold.
- Commit, same edge as capture: if the old pend_valid=1 and old pend_addr!=0, then array[old pend_addr]<=old pend_data.
  - Latency: data presented at edge N is visible in the array after edge N+1.
- Back-to-back writes:
  - Every-cycle we is legal and lossless; the buffer drains and refills on the same edge.
  - Same address on consecutive cycles: the later value wins.
- Write to address 0: captured into the buffer (pend_valid=1) but never committed.
  - Reads of address 0 always return 0.
  - Reads of address 0 never raise a hazard.
- Reads (combinational, per port i):
  - rd_addri==0 -> rd_datai=0.
  - Otherwise, if the match condition holds (pend_valid && pend_addr==rd_addri): behaviour per Optional Feature.
  - Otherwise rd_datai=array[rd_addri].
- Both ports may read the same address; the result is identical on both ports.
- Reset mid-operation: a pending write is discarded; it is not committed.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined:
  - On the match condition, rd_datai=pend_data (bypass).
  - rd_hazardi is tied to 0.
- Undefined:
  - On the match condition, rd_datai=array[rd_addri] (stale value).
  - rd_hazardi=1 so that upstream control stalls one cycle.
- pend_valid, write latency and reset behaviour are identical in both builds.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults.
  - ZERO_REG constant (5'd0).
  - NUM_REGS = 2**ADDR_W.
  - Write-back request struct/typedef {we, addr, data}.
- One natural sub-module, wb_pend_buf:
  - One-entry capture register (pend_valid/pend_addr/pend_data) with async active-low reset.
  - Instantiated once, feeding both the commit logic and the read-match logic.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with writes outstanding -> all reads 0, pend_valid=0, hazards 0 immediately, without a clock edge.
- Basic write:
  - Stimulus: we=1, wr_addr=5'd12, wr_data=32'h0000_00AA at edge N.
  - Required: after edge N+1 with we=0, rd_addr1=12 -> 32'hAA, rd_hazard1=0.
- Forward/hazard window:
  - Stimulus: after edge N (from the Basic write scenario), rd_addr2=12.
  - With REGFILE_WB_FORWARD_EN: rd_data2=32'hAA, rd_hazard2=0.
  - Without: rd_data2=0, rd_hazard2=1.
- Back-to-back writes:
  - Stimulus: write addr 6=32'h11, then addr 6=32'h22 on consecutive edges.
  - Required: final read of 6 = 32'h22; with forwarding, the read between the two edges shows 32'h11.
- Zero register: write addr 0=32'hFFFF_FFFF -> pend_valid=1 for one cycle, rd_data(0)=0 always, no hazard.
- Dual-port same address: write addr 31=32'hDEAD_BEEF, both read ports at 31 -> identical data after commit.
